// File: rtl/icache_loader_ctrl.sv
// Boot-time instruction-cache loader: parses a little-endian word-count header,
// packs the following bytes into instruction words and writes them to the cache.
module icache_loader_ctrl #(
  parameter int unsigned            ADDR_WID  = 32,
  parameter int unsigned            INSTR_WID = 32,
  parameter int unsigned            DEPTH     = 100,
  parameter logic [ADDR_WID-1:0]    BASE_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  boot_start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  byte_ready_o,
  output logic                  wr_instr_en_o,
  output logic [INSTR_WID-1:0]  wr_instr_o,
  output logic [ADDR_WID-1:0]   cache_addr_o,
  input  logic [ADDR_WID-1:0]   fetch_addr_i,
  output logic                  fetch_stall_o,
  output logic                  load_done_o,
  output logic                  load_err_o
);

  localparam int unsigned BYTES_PER_WORD = INSTR_WID / 8;
  localparam int unsigned HDR_BYTES      = 4;
  localparam int unsigned CNT_W          = 32;
  // One index serves both the 4-byte header and the word assembly.
  localparam int unsigned IDX_W = (BYTES_PER_WORD > HDR_BYTES) ? $clog2(BYTES_PER_WORD) : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t               state_q, state_n;
  logic [ADDR_WID-1:0]  fill_addr_q;
  logic [IDX_W-1:0]     idx_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     words_q;

  logic                 xfer;
  logic                 start;
  logic                 hdr_last;
  logic                 word_last;
  logic [CNT_W-1:0]     hdr_cnt;
  logic                 ready_n;
  logic                 wr_en_n;
  logic                 done_n;
  logic                 err_n;
  logic                 stall_n;

  assign xfer      = byte_valid_i & byte_ready_o;
  assign start     = boot_start_i & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
  assign hdr_last  = (idx_q == IDX_W'(HDR_BYTES - 1));
  assign word_last = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  // Header value as it will stand once the current (final) byte is shifted in.
  assign hdr_cnt   = {byte_i, count_q[23:0]};

  // Next-state and next-output decode; outputs are registered from state_n.
  always_comb begin
    state_n = state_q;
    ready_n = 1'b0;
    wr_en_n = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    stall_n = 1'b1;

    case (state_q)
      S_IDLE: if (boot_start_i) state_n = S_HDR;
      S_HDR: begin
        if (xfer && hdr_last) begin
          if (hdr_cnt == '0)                   state_n = S_DONE;
          else if (hdr_cnt > CNT_W'(DEPTH))    state_n = S_ERROR;
          else                                 state_n = S_DATA;
        end
      end
      S_DATA:  if (xfer && word_last) state_n = S_WRITE;
      S_WRITE: begin
        if (words_q + CNT_W'(1) == count_q) state_n = S_DONE;
        else                                state_n = S_DATA;
      end
      S_DONE:  if (boot_start_i) state_n = S_HDR;
      S_ERROR: if (boot_start_i) state_n = S_HDR;
      default: state_n = S_IDLE;
    endcase

    ready_n = (state_n == S_HDR) || (state_n == S_DATA);
    wr_en_n = (state_n == S_WRITE);
    done_n  = (state_n == S_DONE);
    err_n   = (state_n == S_ERROR);
    stall_n = (state_n != S_DONE);
  end

  // State and registered control outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      byte_ready_o  <= 1'b0;
      wr_instr_en_o <= 1'b0;
      load_done_o   <= 1'b0;
      load_err_o    <= 1'b0;
      fetch_stall_o <= 1'b1;
    end else begin
      state_q       <= state_n;
      byte_ready_o  <= ready_n;
      wr_instr_en_o <= wr_en_n;
      load_done_o   <= done_n;
      load_err_o    <= err_n;
      fetch_stall_o <= stall_n;
    end
  end

  // Header capture, word assembly and fill-address bookkeeping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fill_addr_q <= BASE_ADDR;
      idx_q       <= '0;
      count_q     <= '0;
      words_q     <= '0;
      wr_instr_o  <= '0;
    end else if (start) begin
      fill_addr_q <= BASE_ADDR;
      idx_q       <= '0;
      count_q     <= '0;
      words_q     <= '0;
    end else begin
      case (state_q)
        S_HDR: begin
          if (xfer) begin
            for (int i = 0; i < int'(HDR_BYTES); i++) begin
              if (idx_q == IDX_W'(i)) count_q[8*i +: 8] <= byte_i;
            end
            idx_q <= hdr_last ? '0 : idx_q + IDX_W'(1);
          end
        end
        S_DATA: begin
          if (xfer) begin
            for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
              if (idx_q == IDX_W'(i)) wr_instr_o[8*i +: 8] <= byte_i;
            end
            idx_q <= word_last ? '0 : idx_q + IDX_W'(1);
          end
        end
        S_WRITE: begin
          fill_addr_q <= fill_addr_q + ADDR_WID'(BYTES_PER_WORD);
          words_q     <= words_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Fetch owns the cache address port only once loading has completed.
  assign cache_addr_o = load_done_o ? fetch_addr_i : fill_addr_q;

endmodule

// File: tb/tb_icache_loader_ctrl.sv
// Directed bench for icache_loader_ctrl: cycle table for a two-word load,
// then hand sequences for empty/oversized headers, gapped source, reset and BASE_ADDR.
module tb_icache_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_start;
  logic        byte_valid;
  logic [7:0]  byte_d;
  logic [31:0] fetch_addr;

  logic        a_ready, a_en, a_stall, a_done, a_err;
  logic [31:0] a_instr, a_addr;
  logic        b_ready, b_en, b_stall, b_done, b_err;
  logic [31:0] b_instr, b_addr;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] a_log_addr[$];
  logic [31:0] a_log_data[$];
  logic [31:0] b_log_addr[$];
  logic [31:0] b_log_data[$];

  always #5 clk = ~clk;

  icache_loader_ctrl dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .boot_start_i(boot_start),
    .byte_valid_i(byte_valid), .byte_i(byte_d), .byte_ready_o(a_ready),
    .wr_instr_en_o(a_en), .wr_instr_o(a_instr), .cache_addr_o(a_addr),
    .fetch_addr_i(fetch_addr), .fetch_stall_o(a_stall),
    .load_done_o(a_done), .load_err_o(a_err)
  );

  icache_loader_ctrl #(.BASE_ADDR(32'h100)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .boot_start_i(boot_start),
    .byte_valid_i(byte_valid), .byte_i(byte_d), .byte_ready_o(b_ready),
    .wr_instr_en_o(b_en), .wr_instr_o(b_instr), .cache_addr_o(b_addr),
    .fetch_addr_i(fetch_addr), .fetch_stall_o(b_stall),
    .load_done_o(b_done), .load_err_o(b_err)
  );

  // Record every write strobe seen by either instance.
  always @(negedge clk) begin
    if (a_en) begin
      a_log_addr.push_back(a_addr);
      a_log_data.push_back(a_instr);
    end
    if (b_en) begin
      b_log_addr.push_back(b_addr);
      b_log_data.push_back(b_instr);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Offer one byte and hold it until the controller takes it.
  task automatic put_byte(input logic [7:0] b);
    int   c = 0;
    logic got = 1'b0;
    byte_valid = 1'b1;
    byte_d     = b;
    while (!got && c < 20) begin
      #1;
      got = a_ready;
      @(negedge clk);
      c++;
    end
    byte_valid = 1'b0;
    chk("byte_accept", 64'(got), 64'(1));
  endtask

  task automatic boot_pulse();
    boot_start = 1'b1;
    @(negedge clk);
    boot_start = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (!a_done && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", 64'(a_done), 64'(1));
  endtask

  typedef struct {
    logic        boot;
    logic        valid;
    logic [7:0]  b;
    logic [31:0] faddr;
    logic        ready;
    logic        en;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        stall;
    logic        done;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int          n;
    int          idx;
    logic        tog;
    logic        pend;
    logic        xf;
    logic [7:0]  stream[$];

    // boot, valid, byte, fetch | ready, en, instr, addr, stall, done
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 32'h0,  1'b0, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'h02, 32'h0,  1'b1, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'h00, 32'h0,  1'b1, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 32'h0,  1'b1, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 8'h00, 32'h0,  1'b1, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 8'h13, 32'h0,  1'b1, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 32'h0,  1'b1, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 32'h0,  1'b1, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 32'h0,  1'b1, 1'b0, 32'h0,        32'h0,  1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h93, 32'h0,  1'b0, 1'b1, 32'h00000013, 32'h0,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h93, 32'h0,  1'b1, 1'b0, 32'h0,        32'h4,  1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 32'h0,  1'b1, 1'b0, 32'h0,        32'h4,  1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h10, 32'h0,  1'b1, 1'b0, 32'h0,        32'h4,  1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 32'h0,  1'b1, 1'b0, 32'h0,        32'h4,  1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 32'h0,  1'b0, 1'b1, 32'h00100093, 32'h4,  1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 8'h00, 32'h8,  1'b0, 1'b0, 32'h0,        32'h8,  1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 8'h00, 32'h40, 1'b0, 1'b0, 32'h0,        32'h40, 1'b0, 1'b1};

    rst_n = 1'b0; boot_start = 1'b0; byte_valid = 1'b0; byte_d = 8'h00; fetch_addr = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(a_ready), 64'(0));
    chk("rst_en",    64'(a_en),    64'(0));
    chk("rst_instr", 64'(a_instr), 64'(0));
    chk("rst_addr",  64'(a_addr),  64'(0));
    chk("rst_stall", 64'(a_stall), 64'(1));
    chk("rst_done",  64'(a_done),  64'(0));
    chk("rst_err",   64'(a_err),   64'(0));
    rst_n = 1'b1;

    // Two-word load, cycle by cycle.
    for (int i = 0; i < 17; i++) begin
      boot_start = vecs[i].boot;
      byte_valid = vecs[i].valid;
      byte_d     = vecs[i].b;
      fetch_addr = vecs[i].faddr;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(a_ready), 64'(vecs[i].ready));
      chk($sformatf("v%0d_en", i),    64'(a_en),    64'(vecs[i].en));
      chk($sformatf("v%0d_addr", i),  64'(a_addr),  64'(vecs[i].addr));
      chk($sformatf("v%0d_stall", i), 64'(a_stall), 64'(vecs[i].stall));
      chk($sformatf("v%0d_done", i),  64'(a_done),  64'(vecs[i].done));
      chk($sformatf("v%0d_err", i),   64'(a_err),   64'(0));
      if (vecs[i].en) chk($sformatf("v%0d_instr", i), 64'(a_instr), 64'(vecs[i].instr));
      @(negedge clk);
    end
    chk("t1_writes", 64'(a_log_addr.size()), 64'(2));

    // Zero-length header: straight to DONE, no write.
    n = a_log_addr.size();
    boot_pulse();
    chk("t2_done_cleared", 64'(a_done), 64'(0));
    put_byte(8'h00); put_byte(8'h00); put_byte(8'h00);
    chk("t2_not_done_yet", 64'(a_done), 64'(0));
    put_byte(8'h00);
    chk("t2_done",   64'(a_done),  64'(1));
    chk("t2_stall",  64'(a_stall), 64'(0));
    chk("t2_addr",   64'(a_addr),  64'(32'h40));
    chk("t2_nowr",   64'(a_log_addr.size()), 64'(n));

    // Oversized header (101 > 100) lands in ERROR; restart clears it.
    boot_pulse();
    put_byte(8'h65); put_byte(8'h00); put_byte(8'h00); put_byte(8'h00);
    chk("t3_err",   64'(a_err),   64'(1));
    chk("t3_stall", 64'(a_stall), 64'(1));
    chk("t3_ready", 64'(a_ready), 64'(0));
    chk("t3_done",  64'(a_done),  64'(0));
    byte_valid = 1'b1; byte_d = 8'hAA;
    repeat (2) @(negedge clk);
    chk("t3_hold_ready", 64'(a_ready), 64'(0));
    chk("t3_hold_err",   64'(a_err),   64'(1));
    byte_valid = 1'b0;
    boot_pulse();
    chk("t3_err_clear", 64'(a_err),   64'(0));
    chk("t3_hdr_ready", 64'(a_ready), 64'(1));

    // Gapped source, already in HDR: one word 0xDEADBEEF.
    n = a_log_addr.size();
    stream = {8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    idx = 0; tog = 1'b0; pend = 1'b0;
    for (int c = 0; c < 200 && idx < 8; c++) begin
      if (!pend) tog = !tog;
      byte_valid = pend ? 1'b1 : tog;
      byte_d     = stream[idx];
      #1;
      xf   = byte_valid && a_ready;
      pend = byte_valid && !xf;
      @(negedge clk);
      if (xf) idx++;
    end
    byte_valid = 1'b0;
    chk("t4_consumed", 64'(idx), 64'(8));
    wait_done();
    chk("t4_writes", 64'(a_log_addr.size()), 64'(n + 1));
    if (a_log_addr.size() == n + 1) begin
      chk("t4_wr_addr", 64'(a_log_addr[n]), 64'(32'h0));
      chk("t4_wr_data", 64'(a_log_data[n]), 64'(32'hDEADBEEF));
    end

    // Reset in the middle of the first word.
    boot_pulse();
    put_byte(8'h02); put_byte(8'h00); put_byte(8'h00); put_byte(8'h00);
    put_byte(8'h21); put_byte(8'h43);
    n = a_log_addr.size();
    rst_n = 1'b0;
    #1;
    chk("t5_ready", 64'(a_ready), 64'(0));
    chk("t5_en",    64'(a_en),    64'(0));
    chk("t5_instr", 64'(a_instr), 64'(0));
    chk("t5_addr",  64'(a_addr),  64'(0));
    chk("t5_stall", 64'(a_stall), 64'(1));
    chk("t5_done",  64'(a_done),  64'(0));
    chk("t5_err",   64'(a_err),   64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("t5_nowr", 64'(a_log_addr.size()), 64'(n));
    boot_pulse();
    put_byte(8'h02); put_byte(8'h00); put_byte(8'h00); put_byte(8'h00);
    put_byte(8'h44); put_byte(8'h33); put_byte(8'h22); put_byte(8'h11);
    put_byte(8'h88); put_byte(8'h77); put_byte(8'h66); put_byte(8'h55);
    wait_done();
    chk("t5_writes", 64'(a_log_addr.size()), 64'(n + 2));
    if (a_log_addr.size() == n + 2) begin
      chk("t5_wr0_addr", 64'(a_log_addr[n]),     64'(32'h0));
      chk("t5_wr0_data", 64'(a_log_data[n]),     64'(32'h11223344));
      chk("t5_wr1_addr", 64'(a_log_addr[n + 1]), 64'(32'h4));
      chk("t5_wr1_data", 64'(a_log_data[n + 1]), 64'(32'h55667788));
    end

    // boot_start during DATA is ignored; second instance writes at BASE_ADDR.
    n = a_log_addr.size();
    idx = b_log_addr.size();
    boot_pulse();
    put_byte(8'h01); put_byte(8'h00); put_byte(8'h00); put_byte(8'h00);
    put_byte(8'h78);
    boot_start = 1'b1;
    put_byte(8'h56);
    boot_start = 1'b0;
    put_byte(8'h34); put_byte(8'h12);
    wait_done();
    chk("t6_writes", 64'(a_log_addr.size()), 64'(n + 1));
    if (a_log_addr.size() == n + 1) begin
      chk("t6_wr_addr", 64'(a_log_addr[n]), 64'(32'h0));
      chk("t6_wr_data", 64'(a_log_data[n]), 64'(32'h12345678));
    end
    chk("t6_b_writes", 64'(b_log_addr.size()), 64'(idx + 1));
    if (b_log_addr.size() == idx + 1) begin
      chk("t6_b_addr", 64'(b_log_addr[idx]), 64'(32'h100));
      chk("t6_b_data", 64'(b_log_data[idx]), 64'(32'h12345678));
    end
    chk("t6_b_done", 64'(b_done), 64'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/icache_loader_ctrl.md
Name: icache_loader_ctrl

Overview:
- Boot-time controller that sequences program loading into the instruction cache and owns the cache address port.
- Accepts a byte stream (e.g. from a UART receiver) carrying a 32-bit little-endian word-count header followed by instruction bytes. Assembles the bytes into words and issues one cache write per word at auto-incrementing byte addresses.
- Stalls CPU fetch until the load completes, then hands the cache address port to the fetch stage.

Parameters:
- ADDR_WID, 32, cache address width (byte address).
- INSTR_WID, 32, instruction width; must be a multiple of 8.
- DEPTH, 100, cache capacity in words; headers with count > DEPTH are rejected.
- BASE_ADDR, 0, byte address of the first loaded word.
- BYTES_PER_WORD, INSTR_WID/8, derived; not overridden.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- boot_start_i  in  1  pulse; starts a load from IDLE, DONE or ERROR.
- byte_valid_i  in  1  source has a byte.
- byte_i  in  8  stream byte.
- byte_ready_o  out  1  controller accepts byte; transfer when byte_valid_i & byte_ready_o.
- wr_instr_en_o  out  1  cache write strobe, one cycle per word.
- wr_instr_o  out  INSTR_WID  assembled word.
- cache_addr_o  out  ADDR_WID  cache address: fill address while loading, else fetch_addr_i.
- fetch_addr_i  in  ADDR_WID  CPU fetch address.
- fetch_stall_o  out  1  CPU must hold PC.
- load_done_o  out  1  load finished successfully.
- load_err_o  out  1  header count exceeded DEPTH.

Behaviour:
- Reset: state IDLE, byte_ready_o=0, wr_instr_en_o=0, wr_instr_o=0, fill addr=BASE_ADDR, byte index=0, word counter=0, fetch_stall_o=1, load_done_o=0, load_err_o=0.
- States: IDLE, HDR, DATA, WRITE, DONE, ERROR.
- IDLE: boot_start_i=1 -> HDR next cycle; clears fill addr to BASE_ADDR, byte index, count, done and err.
- HDR: byte_ready_o=1. Each transfer shifts the byte into count bits [8*i+7:8*i], i=0..3.
  - After the 4th byte: count=0 -> DONE; count>DEPTH -> ERROR; else -> DATA.
- DATA: byte_ready_o=1. Byte i lands in wr_instr_o bits [8*i+7:8*i], little-endian.
  - On the BYTES_PER_WORD-th transfer -> WRITE.
- WRITE: byte_ready_o=0 and wr_instr_en_o=1 for exactly one cycle, with cache_addr_o = fill addr and wr_instr_o stable.
  - Next cycle: fill addr += BYTES_PER_WORD and words_written += 1.
  - If words_written equals count -> DONE, else -> DATA.
- Byte-to-write latency: WRITE strobe occurs the cycle after the final byte of a word is accepted.
- Sustained throughput: one word per BYTES_PER_WORD+1 cycles.
- DONE: load_done_o=1, fetch_stall_o=0, byte_ready_o=0, cache_addr_o=fetch_addr_i combinationally.
- ERROR: load_err_o=1, fetch_stall_o=1, byte_ready_o=0.
- fetch_stall_o=1 in every state except DONE.
- cache_addr_o = fill addr in all states except DONE.
- boot_start_i is ignored in HDR, DATA and WRITE. In DONE or ERROR it restarts via HDR, clearing done and err on the next edge.
- byte_valid_i while byte_ready_o=0: the byte is not consumed; the source must hold it.
- Fill addr wraps modulo 2^ADDR_WID; this is unreachable when DEPTH*BYTES_PER_WORD + BASE_ADDR < 2^ADDR_WID.
- Reset asserted mid-load: all state returns to reset values immediately (asynchronous). Partial words are discarded and no write strobe is emitted.
- Count comparison is unsigned 32-bit.

Test Plan:
- Reset, boot_start_i pulse, stream header 02 00 00 00 then bytes 13 00 00 00 93 00 10 00 with byte_valid_i always high:
  - wr_instr_en_o pulses twice, with (addr 0x0, data 0x00000013) and (addr 0x4, data 0x00100093).
  - load_done_o=1 and fetch_stall_o=0 the cycle after the second write; cache_addr_o then follows fetch_addr_i=0x8.
- Header 00 00 00 00: no write strobe; DONE the cycle after the 4th header byte is accepted.
- Header 65 00 00 00 (101 > DEPTH=100): load_err_o=1, fetch_stall_o stays 1, byte_ready_o=0.
  - A following boot_start_i re-enters HDR and clears load_err_o.
- Source toggles byte_valid_i every other cycle with a 1-word payload 0xDEADBEEF:
  - Single write of 0xDEADBEEF at addr 0.
  - No byte is lost or duplicated; bytes offered during WRITE are held until DATA.
- Deassert rst_n_i after the 2nd data byte of word 1:
  - All outputs return to reset values asynchronously and no write strobe appears.
  - A fresh load afterwards writes correctly starting at addr 0.
- boot_start_i asserted during DATA: ignored, load completes normally. BASE_ADDR=0x100 with 1 word: write at 0x100.
